// File: rtl/hex_digit_sequencer.sv
// rtl/hex_digit_sequencer.sv - step-rate hex digit counter with load, pause and dp blink
// Feeds the hex and dp inputs of the 7-segment decoder.
module hex_digit_sequencer #(
  parameter int TICK_DIV  = 50000000,
  parameter int MAX_VALUE = 15
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] Hex,
  output logic       dp,
  output logic       tick,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);
  localparam logic [3:0]    MAXV = 4'(MAX_VALUE);

  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_next;
  logic [3:0]    hex_step;
  logic          step_wrap;
  logic [3:0]    load_clamped;

  always_comb begin
    prescaler_next = (prescaler == TERM) ? '0 : prescaler + PW'(1);
  end

  // Wrap is compared against MAX_VALUE explicitly so decimal mode works.
  always_comb begin
    hex_step  = Hex;
    step_wrap = 1'b0;
    if (up) begin
      if (Hex == MAXV) begin
        hex_step  = 4'd0;
        step_wrap = 1'b1;
      end else begin
        hex_step = Hex + 4'd1;
      end
    end else begin
      if (Hex == 4'd0) begin
        hex_step  = MAXV;
        step_wrap = 1'b1;
      end else begin
        hex_step = Hex - 4'd1;
      end
    end
  end

  always_comb begin
    load_clamped = (load_val > MAXV) ? MAXV : load_val;
  end

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      prescaler <= '0;
      Hex       <= 4'd0;
      dp        <= 1'b1;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      prescaler <= '0;
      Hex       <= load_clamped;
      dp        <= 1'b1;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (en) begin
      prescaler <= prescaler_next;
      dp        <= (prescaler_next < HALF);
      if (prescaler == TERM) begin
        Hex  <= hex_step;
        tick <= 1'b1;
        wrap <= step_wrap;
      end else begin
        tick <= 1'b0;
        wrap <= 1'b0;
      end
    end else begin
      // Paused: prescaler, Hex and dp hold so the period resumes where it stopped.
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule
